// File: rtl/ripple_cla8_pkg.sv
// ----------------------------------------------------------------------------
// ripple_cla8_pkg
// Shared constants for the 8-bit ripple-of-CLA adder.
//   CLA_W  : width of one carry-lookahead slice
//   DATA_W : operand / sum width of the full adder
// ----------------------------------------------------------------------------
package ripple_cla8_pkg;

    localparam int CLA_W  = 4;
    localparam int DATA_W = 8;

endpackage : ripple_cla8_pkg

// File: rtl/ripple_cla8_cla4.sv
// ----------------------------------------------------------------------------
// cla4
// 4-bit carry-lookahead slice. Every carry is written in fully expanded
// lookahead form, so no carry ripples between bits inside the slice.
// Ports:
//   a, b : slice operand bits
//   ci   : carry into bit 0 of the slice
//   s    : slice sum bits
//   co   : carry out of bit 3
//   pg   : group propagate (all four bits propagate)
//   gg   : group generate (slice generates a carry regardless of ci)
// ----------------------------------------------------------------------------
module cla4
    import ripple_cla8_pkg::*;
(
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             ci,
    output logic [CLA_W-1:0] s,
    output logic             co,
    output logic             pg,
    output logic             gg
);

    logic [CLA_W-1:0] g_s;
    logic [CLA_W-1:0] p_s;
    logic [CLA_W-1:0] c_s;   // c_s[i] is the carry into bit i

    assign g_s = a & b;
    assign p_s = a ^ b;

    assign c_s[0] = ci;
    assign c_s[1] = g_s[0]
                  | (p_s[0] & ci);
    assign c_s[2] = g_s[1]
                  | (p_s[1] & g_s[0])
                  | (p_s[1] & p_s[0] & ci);
    assign c_s[3] = g_s[2]
                  | (p_s[2] & g_s[1])
                  | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & ci);

    // Group terms let a future block-level lookahead skip this slice's carry chain.
    assign pg = &p_s;
    assign gg = g_s[3]
              | (p_s[3] & g_s[2])
              | (p_s[3] & p_s[2] & g_s[1])
              | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

    assign co = gg | (pg & ci);

    assign s = p_s ^ c_s;

endmodule : cla4

// File: rtl/ripple_cla8.sv
// ----------------------------------------------------------------------------
// ripple_cla8
// 8-bit registered adder: two 4-bit CLA slices, the low slice's carry-out
// rippling into the high slice. Operands are sampled on an enabled rising
// edge; sum, carry-out and ready are registered with one cycle of latency.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   en     : sample operands and update the result on this edge
//   A, B   : unsigned operands
//   c_in   : carry into bit 0
//   Output : registered sum (modulo 256)
//   c_out  : registered carry out of bit 7
//   ready  : result registers hold the previous edge's enabled result
// ----------------------------------------------------------------------------
module ripple_cla8
    import ripple_cla8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              c_in,
    output logic [DATA_W-1:0] Output,
    output logic              c_out,
    output logic              ready
);

    logic [DATA_W-1:0] sum_s;
    logic              c4_s;
    logic              cy_s;
    // Group propagate/generate are reserved for a later block-lookahead stage.
    logic [1:0]        unused_pg_s;
    logic [1:0]        unused_gg_s;

    logic [DATA_W-1:0] sum_d;
    logic [DATA_W-1:0] sum_q;
    logic              c_out_d;
    logic              c_out_q;
    logic              ready_d;
    logic              ready_q;

    cla4 u_cla_lo (
        .a  (A[CLA_W-1:0]),
        .b  (B[CLA_W-1:0]),
        .ci (c_in),
        .s  (sum_s[CLA_W-1:0]),
        .co (c4_s),
        .pg (unused_pg_s[0]),
        .gg (unused_gg_s[0])
    );

    cla4 u_cla_hi (
        .a  (A[DATA_W-1:CLA_W]),
        .b  (B[DATA_W-1:CLA_W]),
        .ci (c4_s),
        .s  (sum_s[DATA_W-1:CLA_W]),
        .co (cy_s),
        .pg (unused_pg_s[1]),
        .gg (unused_gg_s[1])
    );

    // Next-state for the result registers: load on enable, otherwise hold and drop ready.
    always_comb begin
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ready_d = 1'b0;
        if (en) begin
            sum_d   = sum_s;
            c_out_d = cy_s;
            ready_d = 1'b1;
        end else begin
            sum_d   = sum_q;
            c_out_d = c_out_q;
            ready_d = 1'b0;
        end
    end

    // Result register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= {DATA_W{1'b0}};
            c_out_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ready_q <= ready_d;
        end
    end

    assign Output = sum_q;
    assign c_out  = c_out_q;
    assign ready  = ready_q;

endmodule : ripple_cla8

// File: tb/tb_ripple_cla8.sv
// ----------------------------------------------------------------------------
// tb_ripple_cla8
// Self-checking bench for ripple_cla8. Expected {c_out, Output} values are
// computed from a plain 9-bit addition when operands are driven, queued, and
// popped when the registered result is sampled one edge later.
// ----------------------------------------------------------------------------
module tb_ripple_cla8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic [7:0] dut_sum;
    logic       dut_cout;
    logic       dut_ready;

    logic [8:0] exp_q[$];
    logic [8:0] held;      // last result the registers should be holding
    logic [8:0] exp;
    int         checks;
    int         errors;

    ripple_cla8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .A      (a),
        .B      (b),
        .c_in   (c_in),
        .Output (dut_sum),
        .c_out  (dut_cout),
        .ready  (dut_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue the expected result when enabled,
    // then advance to just after the next rising edge.
    task automatic drive(input logic e, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci);
        en   = e;
        a    = av;
        b    = bv;
        c_in = ci;
        if (e) exp_q.push_back({1'b0, av} + {1'b0, bv} + {8'h00, ci});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        c_in  = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dut_ready, dut_cout, dut_sum} !== 10'h000) begin
                errors++;
                $display("FAIL reset[%0d]: ready=%b c_out=%b Output=%h, required 0/0/00",
                         i, dut_ready, dut_cout, dut_sum);
            end
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        rst_n = 1'b1;
        held = 9'h000;
    endtask

    task automatic test_basic_add;
        drive(1'b0, 8'd12, 8'd1, 1'b0);
        checks++;
        if (dut_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_pre_en: ready=%b, required 0", dut_ready);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'd12, 8'd1, 1'b0);
            exp = exp_q.pop_front();
            held = exp;
            checks++;
            if ({dut_ready, dut_cout, dut_sum} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL basic_add[%0d]: ready=%b c_out=%b Output=%0d, required 1/%b/%0d",
                         i, dut_ready, dut_cout, dut_sum, exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_enable_drop;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h77, 8'h66, 1'b1);
            checks++;
            if ({dut_ready, dut_cout, dut_sum} !== {1'b0, held}) begin
                errors++;
                $display("FAIL en_drop[%0d]: ready=%b c_out=%b Output=%h, required 0/%b/%h",
                         i, dut_ready, dut_cout, dut_sum, held[8], held[7:0]);
            end
        end
        drive(1'b1, 8'h0F, 8'h01, 1'b0);
        exp = exp_q.pop_front();
        held = exp;
        checks++;
        if ({dut_ready, dut_cout, dut_sum} !== {1'b1, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL c4_ripple: ready=%b c_out=%b Output=%h, required 1/0/10",
                     dut_ready, dut_cout, dut_sum);
        end
        checks++;
        if ({dut_cout, dut_sum} !== exp) begin
            errors++;
            $display("FAIL c4_ripple_sb: got %h, required %h", {dut_cout, dut_sum}, exp);
        end
    endtask

    task automatic test_carry_wrap;
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if ({dut_ready, dut_cout, dut_sum} !== {1'b1, 1'b1, 8'h00} || exp !== 9'h100) begin
            errors++;
            $display("FAIL wrap: ready=%b c_out=%b Output=%h, required 1/1/00",
                     dut_ready, dut_cout, dut_sum);
        end
        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        exp = exp_q.pop_front();
        held = exp;
        checks++;
        if ({dut_ready, dut_cout, dut_sum} !== {1'b1, 1'b1, 8'hFF} || exp !== 9'h1FF) begin
            errors++;
            $display("FAIL max_case: ready=%b c_out=%b Output=%h, required 1/1/FF",
                     dut_ready, dut_cout, dut_sum);
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 8'h5A, 8'h33, 1'b1);
        exp = exp_q.pop_front();
        checks++;
        if ({dut_ready, dut_cout, dut_sum} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL pre_async: ready=%b got %h, required 1/%h",
                     dut_ready, {dut_cout, dut_sum}, exp);
        end
        // Pulse reset well between edges; en stays high throughout.
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_ready, dut_cout, dut_sum} !== 10'h000) begin
            errors++;
            $display("FAIL async_clear: ready=%b c_out=%b Output=%h, required 0/0/00",
                     dut_ready, dut_cout, dut_sum);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({dut_ready, dut_cout, dut_sum} !== 10'h000) begin
            errors++;
            $display("FAIL async_hold: ready=%b c_out=%b Output=%h, required 0/0/00",
                     dut_ready, dut_cout, dut_sum);
        end
        drive(1'b1, 8'd3, 8'd4, 1'b1);
        exp = exp_q.pop_front();
        held = exp;
        checks++;
        if ({dut_ready, dut_cout, dut_sum} !== {1'b1, 1'b0, 8'd8}) begin
            errors++;
            $display("FAIL post_reset: ready=%b c_out=%b Output=%0d, required 1/0/8",
                     dut_ready, dut_cout, dut_sum);
        end
    endtask

    task automatic test_random;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)),
                  1'($urandom_range(1)));
            exp = exp_q.pop_front();
            checks++;
            if ({dut_ready, dut_cout, dut_sum} !== {1'b1, exp}) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: ready=%b got %h, required 1/%h",
                             i, dut_ready, {dut_cout, dut_sum}, exp);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        c_in   = 1'b0;
        held   = 9'h000;
        test_reset();
        test_basic_add();
        test_enable_drop();
        test_carry_wrap();
        test_async_reset();
        test_random();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ripple_cla8
